// File: rtl/rst_sync_gen.sv
// Reset generator for downstream RN pins. The output asserts asynchronously and releases synchronously.
// Release is held off by a stretch counter, by HOLD, and by a software reset handshake.
module rst_sync_gen #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       HOLD,
  input  logic       SW_RST_REQ,
  output logic       SW_RST_ACK,
  output logic       RSTN_OUT,
  output logic [1:0] RST_STATE
);

  localparam logic [1:0] S_ASSERT  = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_SWRST   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rstn;
  logic                   r_ack;

  logic                   w_sync_out;
  logic [1:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_rstn_nxt;
  logic                   w_ack_nxt;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rstn_nxt  = r_rstn;
    // ACK drops once the requester has lowered REQ; it is only set on SWRST completion.
    w_ack_nxt   = r_ack & SW_RST_REQ;
    case (r_state)
      S_ASSERT: begin
        w_rstn_nxt = 1'b0;
        if (w_sync_out && !HOLD) begin
          w_state_nxt = S_STRETCH;
          w_cnt_nxt   = '0;
        end
      end
      S_STRETCH: begin
        w_rstn_nxt = 1'b0;
        if (HOLD) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_RUN;
          w_rstn_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        w_rstn_nxt = 1'b1;
        if (HOLD) begin
          w_state_nxt = S_ASSERT;
          w_rstn_nxt  = 1'b0;
        end else if (SW_RST_REQ && !r_ack) begin
          w_state_nxt = S_SWRST;
          w_cnt_nxt   = '0;
          w_rstn_nxt  = 1'b0;
        end
      end
      S_SWRST: begin
        w_rstn_nxt = 1'b0;
        // HOLD aborts without ACK so a still-pending request is re-honored later.
        if (HOLD) begin
          w_state_nxt = S_ASSERT;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_RUN;
          w_rstn_nxt  = 1'b1;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_ASSERT;
        w_rstn_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= S_ASSERT;
      r_cnt   <= '0;
      r_rstn  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rstn  <= w_rstn_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign RSTN_OUT   = r_rstn;
  assign SW_RST_ACK = r_ack;
  assign RST_STATE  = r_state;

endmodule

// File: tb/tb_rst_sync_gen.sv
// Scenario bench for rst_sync_gen: per-edge expected {RSTN_OUT, RST_STATE, SW_RST_ACK} go through a queue.
module tb_rst_sync_gen;
  typedef logic [3:0] exp_t;

  logic       CLK = 1'b0;
  logic       RN = 1'b0, HOLD = 1'b0, SW_RST_REQ = 1'b0;
  logic       SW_RST_ACK, RSTN_OUT;
  logic [1:0] RST_STATE;
  logic       RN2 = 1'b0, HOLD2 = 1'b0, REQ2 = 1'b0;
  logic       ACK2, RSTN2;
  logic [1:0] STATE2;

  exp_t q[$];
  exp_t exp_v;
  int   total = 0;
  int   bad   = 0;

  wire exp_t obs  = {RSTN_OUT, RST_STATE, SW_RST_ACK};
  wire exp_t obs2 = {RSTN2, STATE2, ACK2};

  rst_sync_gen dut (
    .CLK(CLK), .RN(RN), .HOLD(HOLD), .SW_RST_REQ(SW_RST_REQ),
    .SW_RST_ACK(SW_RST_ACK), .RSTN_OUT(RSTN_OUT), .RST_STATE(RST_STATE)
  );

  rst_sync_gen #(.SYNC_STAGES(3), .STRETCH_CYCLES(1), .CNT_W(8)) dut2 (
    .CLK(CLK), .RN(RN2), .HOLD(HOLD2), .SW_RST_REQ(REQ2),
    .SW_RST_ACK(ACK2), .RSTN_OUT(RSTN2), .RST_STATE(STATE2)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t mk(input logic rstn, input logic [1:0] st, input logic ack);
    return {rstn, st, ack};
  endfunction

  // Expected state after edge e of a release from ASSERT with HOLD=0 (defaults).
  function automatic exp_t rel_exp(input int e);
    if (e < 3)  return mk(1'b0, 2'd0, 1'b0);
    if (e < 19) return mk(1'b0, 2'd1, 1'b0);
    return mk(1'b1, 2'd2, 1'b0);
  endfunction

  task automatic test_reset();
    for (int e = 0; e < 5; e++) begin
      q.push_back(mk(1'b0, 2'd0, 1'b0));
      if (e > 0) begin @(posedge CLK); #1; end else #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset e%0d got=%b exp=%b", e, obs, exp_v); end
    end
  endtask

  task automatic test_powerup(input string nm);
    RN = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      q.push_back(rel_exp(e));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL %s e%0d got=%b exp=%b", nm, e, obs, exp_v); end
    end
  endtask

  task automatic test_async();
    #3 RN = 1'b0;
    q.push_back(mk(1'b0, 2'd0, 1'b0));
    #1;
    exp_v = q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL async_now got=%b exp=%b", obs, exp_v); end
    for (int e = 1; e <= 2; e++) begin
      q.push_back(mk(1'b0, 2'd0, 1'b0));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL async_low e%0d got=%b exp=%b", e, obs, exp_v); end
    end
    test_powerup("async_rec");
  endtask

  task automatic test_hold_stretch();
    // Sub-cycle RN pulse, then HOLD while cnt=10.
    #2 RN = 1'b0;
    #1 RN = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      q.push_back(rel_exp(e));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL hstr_pre e%0d got=%b exp=%b", e, obs, exp_v); end
    end
    HOLD = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      q.push_back(mk(1'b0, 2'd1, 1'b0));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL hstr_hold e%0d got=%b exp=%b", e, obs, exp_v); end
    end
    HOLD = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      q.push_back(k == 16 ? mk(1'b1, 2'd2, 1'b0) : mk(1'b0, 2'd1, 1'b0));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL hstr_rel k%0d got=%b exp=%b", k, obs, exp_v); end
    end
  endtask

  task automatic test_hold_run();
    HOLD = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      q.push_back(mk(1'b0, 2'd0, 1'b0));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL hrun_hold e%0d got=%b exp=%b", e, obs, exp_v); end
    end
    HOLD = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      q.push_back(k == 17 ? mk(1'b1, 2'd2, 1'b0) : mk(1'b0, 2'd1, 1'b0));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL hrun_rel k%0d got=%b exp=%b", k, obs, exp_v); end
    end
  endtask

  task automatic test_swrst();
    SW_RST_REQ = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      q.push_back(e < 17 ? mk(1'b0, 2'd3, 1'b0) : mk(1'b1, 2'd2, 1'b1));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL swrst e%0d got=%b exp=%b", e, obs, exp_v); end
    end
    SW_RST_REQ = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      q.push_back(mk(1'b1, 2'd2, 1'b0));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL swrst_ackclr e%0d got=%b exp=%b", e, obs, exp_v); end
    end
  endtask

  task automatic test_collision();
    SW_RST_REQ = 1'b1;
    HOLD = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      q.push_back(mk(1'b0, 2'd0, 1'b0));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL coll_hold e%0d got=%b exp=%b", e, obs, exp_v); end
    end
    HOLD = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (k < 17)       q.push_back(mk(1'b0, 2'd1, 1'b0));
      else if (k == 17) q.push_back(mk(1'b1, 2'd2, 1'b0));
      else if (k < 34)  q.push_back(mk(1'b0, 2'd3, 1'b0));
      else              q.push_back(mk(1'b1, 2'd2, 1'b1));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL coll_rel k%0d got=%b exp=%b", k, obs, exp_v); end
    end
    SW_RST_REQ = 1'b0;
    q.push_back(mk(1'b1, 2'd2, 1'b0));
    @(posedge CLK); #1;
    exp_v = q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL coll_ackclr got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_rn_in_swrst();
    SW_RST_REQ = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      q.push_back(mk(1'b0, 2'd3, 1'b0));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rnsw_pre e%0d got=%b exp=%b", e, obs, exp_v); end
    end
    #3 RN = 1'b0;
    q.push_back(mk(1'b0, 2'd0, 1'b0));
    #1;
    exp_v = q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rnsw_now got=%b exp=%b", obs, exp_v); end
    #1 RN = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      if (e < 20)       q.push_back(rel_exp(e));
      else if (e < 36)  q.push_back(mk(1'b0, 2'd3, 1'b0));
      else              q.push_back(mk(1'b1, 2'd2, 1'b1));
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rnsw_rec e%0d got=%b exp=%b", e, obs, exp_v); end
    end
    SW_RST_REQ = 1'b0;
    q.push_back(mk(1'b1, 2'd2, 1'b0));
    @(posedge CLK); #1;
    exp_v = q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rnsw_ackclr got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_param_corner();
    RN2 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      if (e < 4)       q.push_back(mk(1'b0, 2'd0, 1'b0));
      else if (e == 4) q.push_back(mk(1'b0, 2'd1, 1'b0));
      else if (e == 5) q.push_back(mk(1'b1, 2'd2, 1'b0));
      else if (e == 6) q.push_back(mk(1'b0, 2'd3, 1'b0));
      else             q.push_back(mk(1'b1, 2'd2, 1'b1));
      if (e == 6) REQ2 = 1'b1;
      @(posedge CLK); #1;
      exp_v = q.pop_front(); total++;
      if (obs2 !== exp_v) begin bad++; $display("FAIL corner e%0d got=%b exp=%b", e, obs2, exp_v); end
    end
    REQ2 = 1'b0;
    q.push_back(mk(1'b1, 2'd2, 1'b0));
    @(posedge CLK); #1;
    exp_v = q.pop_front(); total++;
    if (obs2 !== exp_v) begin bad++; $display("FAIL corner_ackclr got=%b exp=%b", obs2, exp_v); end
  endtask

  initial begin
    test_reset();
    test_powerup("powerup");
    test_async();
    test_hold_stretch();
    test_hold_run();
    test_swrst();
    test_collision();
    test_rn_in_swrst();
    test_param_corner();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
